// File: rtl/instr_fetch.sv
// Fetch stage: owns the fetch PC, issues in-order instruction reads and
// buffers responses as {pc, instr, fault} entries for the instruction queue.
module instr_fetch #(
  parameter int unsigned     XLEN         = 64,
  parameter logic [XLEN-1:0] RESET_PC     = 64'h8000_0000,
  parameter int unsigned     MAX_INFLIGHT = 2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic [XLEN-1:0]  mem_req_addr,
  input  logic             mem_resp_valid,
  input  logic [31:0]      mem_resp_data,
  input  logic             mem_resp_err,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN+33:0] out_data
);

  localparam int unsigned DW = XLEN + 34;
  localparam int unsigned AW =
    (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
  localparam int unsigned CW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic {
    S_RUN,
    S_FAULT
  } state_e;

  state_e state_q, state_d;

  logic [XLEN-1:0] pc_q;
  logic [CW-1:0]   inflight_q;
  logic [CW-1:0]   drop_q;
  logic            boot_q;
  logic            mis_q;

  logic [DW-1:0]   buf_q [MAX_INFLIGHT];
  logic [AW-1:0]   bhead_q;
  logic [AW-1:0]   btail_q;
  logic [CW-1:0]   bcnt_q;

  logic [XLEN-1:0] pcq_q [MAX_INFLIGHT];
  logic [AW-1:0]   phead_q;
  logic [AW-1:0]   ptail_q;

  logic            req_fire;
  logic            resp_keep;
  logic            mis_push;
  logic            push;
  logic            pop;
  logic            credit_ok;
  logic [DW-1:0]   push_data;

  function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
    return (p == AW'(MAX_INFLIGHT - 1)) ? '0 : p + AW'(1);
  endfunction

  assign credit_ok =
    ({1'b0, inflight_q} + {1'b0, bcnt_q}) < (CW+1)'(MAX_INFLIGHT);

  assign req_fire = mem_req_valid && mem_req_ready;

  // Responses are kept only when not owed to a past redirect and not faulted.
  assign resp_keep = mem_resp_valid && !redirect_valid
                  && (drop_q == '0) && (state_q == S_RUN);
  assign mis_push  = mis_q && !redirect_valid;
  assign push      = resp_keep || mis_push;
  assign pop       = out_valid && out_ready && !redirect_valid;

  assign push_data = mis_push
    ? {pc_q, 32'b0, 2'b01}
    : {pcq_q[phead_q], mem_resp_data, mem_resp_err, 1'b0};

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_RUN;
    else     state_q <= state_d;
  end

  // A fault entry stops fetching as soon as it is buffered.
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = (redirect_pc[1:0] != 2'b00) ? S_FAULT : S_RUN;
    end else if (resp_keep && mem_resp_err) begin
      state_d = S_FAULT;
    end
  end

  always_comb begin
    mem_req_valid = !rst && !boot_q && (state_q == S_RUN)
                 && !redirect_valid && credit_ok;
    mem_req_addr  = pc_q;
    out_valid     = !rst && (bcnt_q != '0);
    out_data      = buf_q[bhead_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
      boot_q     <= 1'b1;
      mis_q      <= 1'b0;
      bhead_q    <= '0;
      btail_q    <= '0;
      bcnt_q     <= '0;
      phead_q    <= '0;
      ptail_q    <= '0;
    end else begin
      boot_q     <= 1'b0;
      inflight_q <= inflight_q + CW'(req_fire) - CW'(mem_resp_valid);
      mis_q      <= redirect_valid && (redirect_pc[1:0] != 2'b00);

      // Every response still outstanding after a redirect is stale.
      if (redirect_valid) begin
        drop_q <= inflight_q - CW'(mem_resp_valid);
      end else if (mem_resp_valid && (drop_q != '0)) begin
        drop_q <= drop_q - CW'(1);
      end

      if (redirect_valid) pc_q <= redirect_pc;
      else if (req_fire)  pc_q <= pc_q + XLEN'(4);

      if (req_fire)       ptail_q <= inc(ptail_q);
      if (mem_resp_valid) phead_q <= inc(phead_q);

      if (redirect_valid) begin
        bhead_q <= '0;
        btail_q <= '0;
        bcnt_q  <= '0;
      end else begin
        if (push) btail_q <= inc(btail_q);
        if (pop)  bhead_q <= inc(bhead_q);
        bcnt_q <= bcnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pcq_q[ptail_q] <= pc_q;
    if (push && !rst) buf_q[btail_q] <= push_data;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a queue-based instruction memory
// whose word at address a is a[31:0] + 0x13.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [63:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = 32'h0;
  logic        mem_resp_err = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [97:0] out_data;

  logic        hold = 1'b0;
  logic [63:0] err_addr = '1;
  logic [63:0] pend [$];
  logic [63:0] reqq [$];
  logic [97:0] outq [$];
  logic [63:0] mem_a;
  int          max_pend = 0;
  int          errors = 0;
  int          checks = 0;
  int          rb = 0;
  int          ob = 0;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .mem_resp_err   (mem_resp_err),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data)
  );

  // Memory: accepts fired requests, answers in order one per cycle unless held
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
    end else if (mem_req_valid && mem_req_ready) begin
      pend.push_back(mem_req_addr);
      reqq.push_back(mem_req_addr);
      if (pend.size() > max_pend) max_pend = pend.size();
    end
    #1;
    if (!rst && !hold && pend.size() > 0) begin
      mem_a          = pend.pop_front();
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_a[31:0] + 32'h13;
      mem_resp_err   = (mem_a == err_addr);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = 32'h0;
      mem_resp_err   = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready && !redirect_valid)
      outq.push_back(out_data);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rb = reqq.size();
    ob = outq.size();
  endtask

  task automatic redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
    rb = reqq.size();
    ob = outq.size();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_req_valid: got %b want 0", mem_req_valid);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_out_valid: got %b want 0", out_valid);
    end
    checks++;
    if (mem_req_addr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL rst_pc: got %h want 80000000", mem_req_addr);
    end
    rst = 1'b0;
    rb = reqq.size();
    ob = outq.size();
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_req_valid: got %b want 0", mem_req_valid);
    end
    @(negedge clk);
    checks++;
    if (mem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL boot_req_valid: got %b want 1", mem_req_valid);
    end
  endtask

  task automatic test_stall();
    mem_req_ready = 1'b0;
    do_reset();
    cyc(2);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL stall_a: got %b/%h want 1/80000000",
               mem_req_valid, mem_req_addr);
    end
    cyc(3);
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 64'h8000_0000) begin
      errors++;
      $display("FAIL stall_b: got %b/%h want 1/80000000",
               mem_req_valid, mem_req_addr);
    end
    checks++;
    if (reqq.size() - rb !== 0) begin
      errors++;
      $display("FAIL stall_nofire: got %0d want 0", reqq.size() - rb);
    end
    mem_req_ready = 1'b1;
  endtask

  task automatic test_fetch();
    logic [63:0] pc;
    do_reset();
    cyc(14);
    for (int i = 0; i < 4; i++) begin
      pc = 64'h8000_0000 + 64'(4 * i);
      checks++;
      if (reqq[rb+i] !== pc) begin
        errors++;
        $display("FAIL fetch_req%0d: got %h want %h", i, reqq[rb+i], pc);
      end
    end
    for (int i = 0; i < 3; i++) begin
      pc = 64'h8000_0000 + 64'(4 * i);
      checks++;
      if (outq[ob+i] !== {pc, pc[31:0] + 32'h13, 2'b00}) begin
        errors++;
        $display("FAIL fetch_out%0d: got %h want pc %h", i, outq[ob+i], pc);
      end
    end
    checks++;
    if (max_pend > 2) begin
      errors++;
      $display("FAIL max_outstanding: got %0d want <=2", max_pend);
    end
  endtask

  task automatic test_backpressure();
    int n;
    int bad;
    logic [63:0] pc;
    out_ready = 1'b0;
    do_reset();
    cyc(10);
    checks++;
    if (reqq.size() - rb !== 2) begin
      errors++;
      $display("FAIL bp_reqs: got %0d want 2", reqq.size() - rb);
    end
    checks++;
    if (mem_req_valid !== 1'b0 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_full: got req %b out %b want 0 1",
               mem_req_valid, out_valid);
    end
    out_ready = 1'b1;
    cyc(20);
    n = outq.size() - ob;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      pc = 64'h8000_0000 + 64'(4 * i);
      if (outq[ob+i] !== {pc, pc[31:0] + 32'h13, 2'b00}) bad++;
    end
    checks++;
    if (bad !== 0 || n < 6) begin
      errors++;
      $display("FAIL bp_resume: got %0d bad of %0d want 0 of >=6", bad, n);
    end
  endtask

  task automatic test_redirect();
    hold = 1'b1;
    do_reset();
    cyc(6);
    checks++;
    if (reqq.size() - rb !== 2 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_two_inflight: got %0d/%b want 2/0",
               reqq.size() - rb, mem_req_valid);
    end
    hold = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 64'h1000;
    #1;
    checks++;
    if (mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_no_req: got %b want 0", mem_req_valid);
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    rb = reqq.size();
    ob = outq.size();
    cyc(12);
    checks++;
    if (reqq[rb] !== 64'h1000) begin
      errors++;
      $display("FAIL rd_first_req: got %h want 1000", reqq[rb]);
    end
    checks++;
    if (outq[ob] !== {64'h1000, 32'h1013, 2'b00}) begin
      errors++;
      $display("FAIL rd_first_out: got %h want pc 1000", outq[ob]);
    end
  endtask

  task automatic test_redirect_race();
    int k;
    hold = 1'b1;
    do_reset();
    cyc(6);
    hold = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!mem_resp_valid && k < 10);
    checks++;
    if (mem_resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL race_resp_timeout: got %b want 1", mem_resp_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'h2000;
    @(negedge clk);
    redirect(64'h3000);
    cyc(14);
    checks++;
    if (reqq[rb-1] !== 64'h8000_0004) begin
      errors++;
      $display("FAIL race_no_2000: got %h want 80000004", reqq[rb-1]);
    end
    checks++;
    if (outq[ob] !== {64'h3000, 32'h3013, 2'b00}) begin
      errors++;
      $display("FAIL race_out0: got %h want pc 3000", outq[ob]);
    end
    checks++;
    if (outq[ob+1] !== {64'h3004, 32'h3017, 2'b00}) begin
      errors++;
      $display("FAIL race_out1: got %h want pc 3004", outq[ob+1]);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    cyc(5);
    redirect(64'h1002);
    cyc(10);
    checks++;
    if (outq.size() - ob !== 1 || outq[ob] !== {64'h1002, 32'h0, 2'b01}) begin
      errors++;
      $display("FAIL mis_entry: got %0d entries head %h want 1 pc 1002",
               outq.size() - ob, outq[ob]);
    end
    checks++;
    if (reqq.size() - rb !== 0 || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL mis_no_fetch: got %0d/%b want 0/0",
               reqq.size() - rb, mem_req_valid);
    end
    redirect(64'h2000);
    cyc(10);
    checks++;
    if (reqq[rb] !== 64'h2000) begin
      errors++;
      $display("FAIL mis_resume_req: got %h want 2000", reqq[rb]);
    end
    checks++;
    if (outq[ob] !== {64'h2000, 32'h2013, 2'b00}) begin
      errors++;
      $display("FAIL mis_resume_out: got %h want pc 2000", outq[ob]);
    end
  endtask

  task automatic test_fault_wrap();
    int r;
    err_addr = 64'h8000_0008;
    do_reset();
    cyc(15);
    checks++;
    if (outq.size() - ob !== 3) begin
      errors++;
      $display("FAIL flt_count: got %0d want 3", outq.size() - ob);
    end
    checks++;
    if (outq[ob] !== {64'h8000_0000, 32'h8000_0013, 2'b00}) begin
      errors++;
      $display("FAIL flt_out0: got %h want pc 80000000 ok", outq[ob]);
    end
    checks++;
    if (outq[ob+2] !== {64'h8000_0008, 32'h8000_001b, 2'b10}) begin
      errors++;
      $display("FAIL flt_entry: got %h want pc 80000008 fault 10", outq[ob+2]);
    end
    r = reqq.size();
    cyc(5);
    checks++;
    if (reqq.size() !== r || mem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL flt_stopped: got %0d new/%b want 0/0",
               reqq.size() - r, mem_req_valid);
    end
    err_addr = '1;
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    cyc(10);
    checks++;
    if (reqq[rb] !== 64'hFFFF_FFFF_FFFF_FFFC || reqq[rb+1] !== 64'h0) begin
      errors++;
      $display("FAIL wrap_req: got %h %h want fffffffffffffffc 0",
               reqq[rb], reqq[rb+1]);
    end
    checks++;
    if (outq[ob] !== {64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_000F, 2'b00}) begin
      errors++;
      $display("FAIL wrap_out0: got %h want pc fffffffffffffffc", outq[ob]);
    end
    checks++;
    if (outq[ob+1] !== {64'h0, 32'h13, 2'b00}) begin
      errors++;
      $display("FAIL wrap_out1: got %h want pc 0", outq[ob+1]);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_fetch();
    test_backpressure();
    test_redirect();
    test_redirect_race();
    test_misaligned();
    test_fault_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
